// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and the writeback grant encoding used by the
// arbiter and its scoreboard.
package regfile_pkg;

  localparam int DW           = 32;
  localparam int AW           = 5;
  localparam int NREG         = 2 ** AW;
  localparam int ZERO_REG     = 0;
  localparam int MAX_WAIT_DEF = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REQ0 = 2'd1,
    GNT_REQ1 = 2'd2
  } gnt_e;

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register-file
// write port. Requesters use the master side, the arbiter the slave side.
interface regfile_wb_arbiter_if #(
  parameter int DW = regfile_pkg::DW,
  parameter int AW = regfile_pkg::AW
);
  localparam int NREG = 2 ** AW;

  logic            req0_valid;
  logic [AW-1:0]   req0_addr;
  logic [DW-1:0]   req0_data;
  logic            req0_ready;

  logic            req1_valid;
  logic [AW-1:0]   req1_addr;
  logic [DW-1:0]   req1_data;
  logic            req1_ready;

  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;

  logic [NREG-1:0] busy;
  logic            waw_err;

  logic            we3;
  logic [AW-1:0]   wa3;
  logic [DW-1:0]   wd3;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rsv_valid, rsv_addr,
    input  req0_ready, req1_ready, busy, waw_err,
    input  we3, wa3, wd3
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rsv_valid, rsv_addr,
    output req0_ready, req1_ready, busy, waw_err,
    output we3, wa3, wd3
  );

endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write bitmap for registers reserved by the multi-cycle requester,
// plus sticky detection of pipeline writes that hit a reserved register.
module wb_scoreboard #(
  parameter int AW   = regfile_pkg::AW,
  parameter int NREG = 2 ** AW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_rsv_valid,
  input  logic [AW-1:0]   i_rsv_addr,
  input  logic            i_clr_valid,
  input  logic [AW-1:0]   i_clr_addr,
  input  logic            i_wr_valid,
  input  logic [AW-1:0]   i_wr_addr,
  output logic [NREG-1:0] o_busy,
  output logic            o_waw_err
);
  import regfile_pkg::*;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            r_waw_err;
  logic            w_waw_hit;

  // Reservation is applied after the clear so a same-cycle re-reserve survives.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_valid) begin
      w_busy_nxt[i_clr_addr] = 1'b0;
    end
    if (i_rsv_valid) begin
      w_busy_nxt[i_rsv_addr] = 1'b1;
    end
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  assign w_waw_hit = i_wr_valid && (i_wr_addr != AW'(ZERO_REG)) && r_busy[i_wr_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy    <= '0;
      r_waw_err <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_waw_hit) begin
        r_waw_err <= 1'b1;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_waw_err = r_waw_err;

endmodule : wb_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// Two-source arbiter for the register-file write port: pipeline writeback wins
// by default, the multi-cycle unit is forced through after MAX_WAIT losses.
module regfile_wb_arbiter #(
  parameter int DW       = regfile_pkg::DW,
  parameter int AW       = regfile_pkg::AW,
  parameter int MAX_WAIT = regfile_pkg::MAX_WAIT_DEF
) (
  input logic                 clk,
  input logic                 reset_n,
  regfile_wb_arbiter_if.slave bus
);
  import regfile_pkg::*;

  localparam int LNREG   = 2 ** AW;
  localparam int WAIT_LIM = (MAX_WAIT < 1) ? 1 : MAX_WAIT;
  localparam int CW       = $clog2(WAIT_LIM + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_LIM);

  logic [CW-1:0]    r_starve_cnt;
  gnt_e             w_gnt;
  logic             w_xfer0;
  logic             w_xfer1;
  logic [LNREG-1:0] w_busy;
  logic             w_waw_err;

  // Grants are gated by reset_n so nothing is written once reset asserts.
  always_comb begin
    w_gnt = GNT_NONE;
    if (reset_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_gnt = (r_starve_cnt == CNT_MAX) ? GNT_REQ1 : GNT_REQ0;
      end else if (bus.req0_valid) begin
        w_gnt = GNT_REQ0;
      end else if (bus.req1_valid) begin
        w_gnt = GNT_REQ1;
      end
    end
  end

  assign w_xfer0 = (w_gnt == GNT_REQ0);
  assign w_xfer1 = (w_gnt == GNT_REQ1);

  assign bus.req0_ready = w_xfer0;
  assign bus.req1_ready = w_xfer1;

  always_comb begin
    bus.we3 = 1'b0;
    bus.wa3 = '0;
    bus.wd3 = '0;
    unique case (w_gnt)
      GNT_REQ0: begin
        bus.we3 = (bus.req0_addr != AW'(ZERO_REG));
        bus.wa3 = bus.req0_addr;
        bus.wd3 = bus.req0_data;
      end
      GNT_REQ1: begin
        bus.we3 = (bus.req1_addr != AW'(ZERO_REG));
        bus.wa3 = bus.req1_addr;
        bus.wd3 = bus.req1_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (!bus.req1_valid || w_xfer1) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_MAX) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  wb_scoreboard #(
    .AW   (AW),
    .NREG (LNREG)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_rsv_valid (bus.rsv_valid),
    .i_rsv_addr  (bus.rsv_addr),
    .i_clr_valid (w_xfer1),
    .i_clr_addr  (bus.req1_addr),
    .i_wr_valid  (w_xfer0),
    .i_wr_addr   (bus.req0_addr),
    .o_busy      (w_busy),
    .o_waw_err   (w_waw_err)
  );

  assign bus.busy    = w_busy;
  assign bus.waw_err = w_waw_err;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a behavioural model checked every
// cycle, plus hand-computed expectations along the directed sequence.
module tb_regfile_wb_arbiter;

  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int MAX_WAIT = 3;

  logic clk;
  logic reset_n;

  regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  regfile_wb_arbiter #(
    .DW       (DW),
    .AW       (AW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: which registers are reserved, how long req1 has lost, sticky WAW.
  bit [31:0]     m_busy;
  int            m_wait;
  bit            m_waw;
  bit            h1_pend, h0_pend;
  logic [AW-1:0] h0_a, h1_a;
  logic [DW-1:0] h0_d, h1_d;

  function automatic int exp_grant();
    if (!reset_n) return 0;
    if (bus.req0_valid && bus.req1_valid) return (m_wait == MAX_WAIT) ? 2 : 1;
    if (bus.req0_valid) return 1;
    if (bus.req1_valid) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  = '0;
      m_wait  = 0;
      m_waw   = 1'b0;
      h0_pend = 1'b0;
      h1_pend = 1'b0;
    end else begin : upd
      int g;
      g = exp_grant();
      if (g == 1 && bus.req0_addr != 0 && m_busy[bus.req0_addr]) m_waw = 1'b1;
      if (g == 2) m_busy[bus.req1_addr] = 1'b0;
      if (bus.rsv_valid && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
      if (!bus.req1_valid || g == 2) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
      h0_pend = bus.req0_valid && g != 1;
      h1_pend = bus.req1_valid && g != 2;
      h0_a = bus.req0_addr; h0_d = bus.req0_data;
      h1_a = bus.req1_addr; h1_d = bus.req1_data;
    end
  end

  always @(negedge clk) begin : mon
    int            g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    g  = exp_grant();
    ea = (g == 1) ? bus.req0_addr : (g == 2) ? bus.req1_addr : '0;
    ed = (g == 1) ? bus.req0_data : (g == 2) ? bus.req1_data : '0;
    chk("mon_ready0", 64'(bus.req0_ready), 64'(g == 1));
    chk("mon_ready1", 64'(bus.req1_ready), 64'(g == 2));
    chk("mon_we3", 64'(bus.we3), 64'(g != 0 && ea != 0));
    chk("mon_wa3", 64'(bus.wa3), 64'(ea));
    chk("mon_wd3", 64'(bus.wd3), 64'(ed));
    chk("mon_busy", 64'(bus.busy), 64'(m_busy));
    chk("mon_waw_err", 64'(bus.waw_err), 64'(m_waw));
    if (reset_n && h0_pend && bus.req0_valid)
      chk("req0_stable", 64'({bus.req0_addr, bus.req0_data}), 64'({h0_a, h0_d}));
    if (reset_n && h1_pend && bus.req1_valid)
      chk("req1_stable", 64'({bus.req1_addr, bus.req1_data}), 64'({h1_a, h1_d}));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.rsv_valid  = 1'b0; bus.rsv_addr  = '0;
  endtask

  task automatic set0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d;
  endtask

  task automatic set1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    tick(); tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_waw", 64'(bus.waw_err), 64'd0);
    chk("rst_we3", 64'(bus.we3), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single-source writes
    set0(5'd5, 32'h1234);
    @(negedge clk);
    chk("r5_ready0", 64'(bus.req0_ready), 64'd1);
    chk("r5_we3", 64'(bus.we3), 64'd1);
    chk("r5_wa3", 64'(bus.wa3), 64'd5);
    chk("r5_wd3", 64'(bus.wd3), 64'h1234);
    tick(); idle(); set1(5'd7, 32'hBEEF);
    @(negedge clk);
    chk("r7_ready1", 64'(bus.req1_ready), 64'd1);
    chk("r7_ready0", 64'(bus.req0_ready), 64'd0);
    chk("r7_we3", 64'(bus.we3), 64'd1);
    chk("r7_wa3", 64'(bus.wa3), 64'd7);
    tick(); idle();

    // Starvation guard: two full rounds show the counter restarts from zero
    set0(5'd1, 32'h11); set1(5'd2, 32'h22);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stv_ready0", 64'(bus.req0_ready), 64'((i % 4) != 3));
      chk("stv_ready1", 64'(bus.req1_ready), 64'((i % 4) == 3));
      chk("stv_wa3", 64'(bus.wa3), ((i % 4) == 3) ? 64'd2 : 64'd1);
      tick();
    end
    idle();

    // r0 write and r0 reservation are both inert
    set1(5'd0, 32'hFFFF_FFFF);
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd0;
    @(negedge clk);
    chk("r0_ready1", 64'(bus.req1_ready), 64'd1);
    chk("r0_we3", 64'(bus.we3), 64'd0);
    tick(); idle();
    chk("r0_busy", 64'(bus.busy), 64'd0);

    // Scoreboard set / clear / same-cycle set-wins
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
    tick(); idle();
    chk("sb_set9", 64'(bus.busy), 64'h200);
    set1(5'd9, 32'h99);
    tick(); idle();
    chk("sb_clr9", 64'(bus.busy), 64'd0);
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
    tick(); idle();
    set1(5'd9, 32'h9A); bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
    tick(); idle();
    chk("sb_setwins", 64'(bus.busy), 64'h200);
    set1(5'd9, 32'h9B);
    tick(); idle();
    chk("sb_clr9b", 64'(bus.busy), 64'd0);
    set1(5'd11, 32'hB);
    tick(); idle();
    chk("sb_unrsv", 64'(bus.busy), 64'd0);

    // WAW on a reserved register
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd3;
    tick(); idle();
    set0(5'd3, 32'h55);
    @(negedge clk);
    chk("waw_we3", 64'(bus.we3), 64'd1);
    chk("waw_wd3", 64'(bus.wd3), 64'h55);
    chk("waw_before", 64'(bus.waw_err), 64'd0);
    tick(); idle();
    chk("waw_set", 64'(bus.waw_err), 64'd1);
    tick(); tick();
    chk("waw_sticky", 64'(bus.waw_err), 64'd1);
    chk("waw_busy3", 64'(bus.busy), 64'h8);

    // Reset mid-operation with starve count at 2
    set0(5'd4, 32'h44); set1(5'd6, 32'h66);
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("mrst_ready1", 64'(bus.req1_ready), 64'd0);
    chk("mrst_we3", 64'(bus.we3), 64'd0);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_waw", 64'(bus.waw_err), 64'd0);
    tick();
    chk("mrst_we3_edge", 64'(bus.we3), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_ready1", 64'(bus.req1_ready), 64'(i == 3));
      tick();
    end
    idle();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
